// File: rtl/fifo_mem_arbiter.sv
// Round-robin write-port arbiter and pointer/count controller for a dual-port FIFO memory.
// Memory reads are registered by the macro; rd_valid marks the cycle mem_rdata is meaningful.
module fifo_mem_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int NREQ  = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*WIDTH-1:0]      req_data,
  output logic [NREQ-1:0]            gnt,
  input  logic                       rd_req,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       mem_wclk_en,
  output logic [$clog2(DEPTH)-1:0]   mem_waddr,
  output logic [WIDTH-1:0]           mem_wdata,
  output logic                       mem_rclk_en,
  output logic [$clog2(DEPTH)-1:0]   mem_raddr,
  input  logic [WIDTH-1:0]           mem_rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(NREQ);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wptr_reg, rptr_reg;
  logic [CW-1:0]    count_reg, count_next;
  logic [RW-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [RW-1:0]    win_idx;
  logic             win_found;
  logic             rd_valid_reg;
  logic             wr_ok, rd_ok;
  logic [RW:0]      cand;
  logic [WIDTH-1:0] req_word [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_word[gi] = req_data[gi*WIDTH +: WIDTH];
      assign gnt[gi]      = wr_ok && (win_idx == RW'(gi));
    end
  endgenerate

  // Scan requesters starting at rr_ptr, wrapping modulo NREQ; first asserted wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_reg} + (RW+1)'(k);
      if (cand >= (RW+1)'(NREQ)) begin
        cand = cand - (RW+1)'(NREQ);
      end
      if (!win_found && req[cand[RW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[RW-1:0];
      end
    end
  end

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // Full blocks writes even when a read frees a slot this cycle; empty blocks reads likewise.
  assign wr_ok = win_found && !full && !flush && !RST;
  assign rd_ok = rd_req && !empty && !flush && !RST;

  assign rr_ptr_next = (win_idx == RW'(NREQ-1)) ? '0 : win_idx + RW'(1);

  assign mem_wclk_en = wr_ok;
  assign mem_waddr   = wptr_reg;
  assign mem_wdata   = req_word[win_idx];
  assign mem_rclk_en = rd_ok;
  assign mem_raddr   = rptr_reg;
  assign rd_valid    = rd_valid_reg;
  assign rd_data     = mem_rdata;

  always_comb begin
    count_next = count_reg;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      count_reg    <= '0;
      rr_ptr_reg   <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr_reg   <= wptr_reg + AW'(1);
        rr_ptr_reg <= rr_ptr_next;
      end
      if (rd_ok) begin
        rptr_reg <= rptr_reg + AW'(1);
      end
      count_reg    <= count_next;
      rd_valid_reg <= rd_ok;
    end
  end

endmodule

// File: tb/tb_fifo_mem_arbiter.sv
// Directed bench for fifo_mem_arbiter with a behavioural model of the registered-read memory.
module tb_fifo_mem_arbiter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int NREQ  = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             flush;
  logic [NREQ-1:0]  req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]  gnt;
  logic             rd_req;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             mem_wclk_en;
  logic [3:0]       mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_rclk_en;
  logic [3:0]       mem_raddr;
  logic [WIDTH-1:0] mem_rdata;
  logic             full;
  logic             empty;
  logic [4:0]       count;

  logic [WIDTH-1:0] rdat [NREQ];
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] exp_q [$];
  int checks_done = 0;
  int fail_cnt    = 0;

  assign req_data = {rdat[3], rdat[2], rdat[1], rdat[0]};

  always #5 CLK = ~CLK;

  // Memory macro stand-in: write on edge, read registered with one-cycle latency.
  always @(posedge CLK) begin
    if (mem_wclk_en) mem[mem_waddr] <= mem_wdata;
    if (mem_rclk_en) mem_rdata <= mem[mem_raddr];
  end

  fifo_mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .req(req), .req_data(req_data), .gnt(gnt),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_wclk_en(mem_wclk_en), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_rclk_en(mem_rclk_en), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .full(full), .empty(empty), .count(count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_done++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("chk  %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; flush = 1'b0; req = '0; rd_req = 1'b0;
    for (int i = 0; i < NREQ; i++) rdat[i] = '0;
    mem_rdata = '0;

    // Reset, with requests present to prove gnt stays idle under RST
    req = 4'b1111;
    tick(); tick();
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_wen", mem_wclk_en, 0);
    RST = 1'b0; req = '0;
    tick();
    check_eq("rst_count", count, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_rdvalid", rd_valid, 0);

    // Round-robin with all requesters active
    rdat[0] = 8'hA0; rdat[1] = 8'hA1; rdat[2] = 8'hA2; rdat[3] = 8'hA3;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq("rr_gnt", gnt, 32'(1) << (i % 4));
      check_eq("rr_waddr", mem_waddr, i);
      check_eq("rr_wdata", mem_wdata, 8'hA0 + (i % 4));
      tick();
      check_eq("rr_count", count, i + 1);
    end
    req = '0;

    // Reset mid-stream drops a pending read
    rd_req = 1'b1;
    #1;
    check_eq("ms_ren", mem_rclk_en, 1);
    tick();
    check_eq("ms_rdvalid", rd_valid, 1);
    check_eq("ms_rddata", rd_data, 8'hA0);
    RST = 1'b1;
    #1;
    check_eq("ms_ren_rst", mem_rclk_en, 0);
    tick();
    check_eq("ms_rdvalid_after", rd_valid, 0);
    check_eq("ms_count_after", count, 0);
    check_eq("ms_empty_after", empty, 1);
    RST = 1'b0; rd_req = 1'b0;

    // Fill to full, then blocked write with no pass-through
    req = 4'b0001;
    for (int i = 0; i < DEPTH; i++) begin
      rdat[0] = 8'h40 + 8'(i);
      tick();
    end
    check_eq("fill_count", count, 16);
    check_eq("fill_full", full, 1);
    req = 4'b0100; rdat[2] = 8'h99;
    #1;
    check_eq("full_gnt", gnt, 0);
    check_eq("full_wen", mem_wclk_en, 0);
    rd_req = 1'b1;
    #1;
    check_eq("full_rd_gnt", gnt, 0);
    check_eq("full_rd_ren", mem_rclk_en, 1);
    tick();
    check_eq("full_rd_count", count, 15);
    check_eq("full_rd_data", rd_data, 8'h40);
    rd_req = 1'b0;
    #1;
    check_eq("resume_gnt", gnt, 4'b0100);
    check_eq("resume_waddr", mem_waddr, 0);
    tick();
    check_eq("resume_count", count, 16);
    req = '0;

    // Drain 9 words to reach count 7
    rd_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check_eq("drain_data", rd_data, 8'h41 + 8'(i));
    end
    rd_req = 1'b0;
    tick();
    check_eq("drain_rdvalid", rd_valid, 0);
    check_eq("drain_count", count, 7);

    // Flush overrides simultaneous write and read
    flush = 1'b1; req = 4'b0010; rd_req = 1'b1;
    #1;
    check_eq("flush_gnt", gnt, 0);
    check_eq("flush_wen", mem_wclk_en, 0);
    check_eq("flush_ren", mem_rclk_en, 0);
    tick();
    flush = 1'b0; rd_req = 1'b0; req = 4'b1111;
    #1;
    check_eq("flush_count", count, 0);
    check_eq("flush_empty", empty, 1);
    check_eq("flush_rdvalid", rd_valid, 0);
    check_eq("flush_rrptr_gnt", gnt, 4'b0001);
    req = '0;

    // Three writes then four read requests
    req = 4'b0010;
    rdat[1] = 8'h11; tick();
    rdat[1] = 8'h22; tick();
    rdat[1] = 8'h33; tick();
    req = '0;
    check_eq("rd3_count", count, 3);
    rd_req = 1'b1;
    tick(); check_eq("rd3_v0", rd_valid, 1); check_eq("rd3_d0", rd_data, 8'h11);
    tick(); check_eq("rd3_v1", rd_valid, 1); check_eq("rd3_d1", rd_data, 8'h22);
    tick(); check_eq("rd3_v2", rd_valid, 1); check_eq("rd3_d2", rd_data, 8'h33);
    check_eq("rd3_ren_empty", mem_rclk_en, 0);
    tick();
    check_eq("rd3_v3", rd_valid, 0);
    check_eq("rd3_empty", empty, 1);
    rd_req = 1'b0;

    // Steady state at count 5 with concurrent write and read, across pointer wrap
    req = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      rdat[1] = 8'h50 + 8'(i);
      exp_q.push_back(rdat[1]);
      tick();
    end
    check_eq("ss_count_init", count, 5);
    rd_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rdat[1] = 8'h60 + 8'(i);
      exp_q.push_back(rdat[1]);
      #1;
      check_eq("ss_gnt", gnt, 4'b0010);
      tick();
      check_eq("ss_count", count, 5);
      check_eq("ss_data", rd_data, exp_q.pop_front());
    end
    req = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("ss_drain", rd_data, exp_q.pop_front());
    end
    tick();
    check_eq("ss_end_rdvalid", rd_valid, 0);
    check_eq("ss_end_empty", empty, 1);
    rd_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks_done, fail_cnt);
    $finish;
  end

endmodule
